y86_stage_ctrl: RTL and testbench

Multi-cycle sequencer for the Y86-64 single-cycle datapath. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update by asserting one stage enable per cycle. Memory and writeback are skipped for instructions that do not need them. It handles the data-memory request/acknowledge handshake, derives the processor status code, and counts retired instructions.

---
 rtl/y86_stage_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_y86_stage_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/y86_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 datapath: one stage enable per cycle,
// data-memory handshake with timeout, processor status and retired-instruction count.
//
// state     | meaning
// IDLE      | out of reset, waiting for start_i
// FETCH     | fetch enable; classify icode and fetch faults
// DECODE    | decode enable
// EXECUTE   | execute enable; cnd_i latched
// MEMORY    | memory enable and request; waits for mem_ack_i
// WRITEBACK | register-file write (suppressed for untaken cmovXX)
// PCUPD     | PC update, instruction retires
// HALTED    | stopped with stat_o holding the cause, waiting for start_i
module y86_stage_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic             cnd_i,
    input  logic             mem_ack_i,
    input  logic             dmem_error_i,
    output logic             fetch_en_o,
    output logic             decode_en_o,
    output logic             execute_en_o,
    output logic             memory_en_o,
    output logic             pc_en_o,
    output logic             wb_en_o,
    output logic             mem_req_o,
    output logic [2:0]       stat_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DECODE    = 3'd2;
    localparam logic [2:0] EXECUTE   = 3'd3;
    localparam logic [2:0] MEMORY    = 3'd4;
    localparam logic [2:0] WRITEBACK = 3'd5;
    localparam logic [2:0] PCUPD     = 3'd6;
    localparam logic [2:0] HALTED    = 3'd7;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        nextState;
    logic [2:0]        stat;
    logic [2:0]        nextStat;
    logic [3:0]        icodeQ;
    logic              cndQ;
    logic              cndNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [CNT_W-1:0]  retired;
    logic              wbNext;
    logic              restart;

    function automatic logic usesMem(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: usesMem = 1'b1;
            default:                            usesMem = 1'b0;
        endcase
    endfunction

    function automatic logic writesAfterMem(input logic [3:0] ic);
        case (ic)
            4'h5, 4'h8, 4'h9, 4'hA, 4'hB: writesAfterMem = 1'b1;
            default:                      writesAfterMem = 1'b0;
        endcase
    endfunction

    function automatic logic writesNoMem(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h6: writesNoMem = 1'b1;
            default:          writesNoMem = 1'b0;
        endcase
    endfunction

    assign restart = ((state == IDLE) || (state == HALTED)) && start_i;

    always_comb begin
        nextState = state;
        nextStat  = stat;
        case (state)
            IDLE, HALTED: begin
                if (start_i) begin
                    nextState = FETCH;
                    nextStat  = STAT_AOK;
                end
            end
            FETCH: begin
                if (imem_error_i) begin
                    nextState = HALTED;
                    nextStat  = STAT_ADR;
                end else if (!instr_valid_i || (icode_i > 4'hB)) begin
                    nextState = HALTED;
                    nextStat  = STAT_INS;
                end else if (icode_i == 4'h0) begin
                    nextState = HALTED;
                    nextStat  = STAT_HLT;
                end else begin
                    nextState = DECODE;
                end
            end
            DECODE: nextState = EXECUTE;
            EXECUTE: begin
                if (usesMem(icodeQ))          nextState = MEMORY;
                else if (writesNoMem(icodeQ)) nextState = WRITEBACK;
                else                          nextState = PCUPD;
            end
            MEMORY: begin
                if (mem_ack_i) begin
                    if (dmem_error_i) begin
                        nextState = HALTED;
                        nextStat  = STAT_ADR;
                    end else if (writesAfterMem(icodeQ)) begin
                        nextState = WRITEBACK;
                    end else begin
                        nextState = PCUPD;
                    end
                end else if (waitCnt == WAIT_LAST) begin
                    nextState = HALTED;
                    nextStat  = STAT_ADR;
                end
            end
            WRITEBACK: nextState = PCUPD;
            PCUPD:     nextState = FETCH;
            default:   nextState = IDLE;
        endcase
    end

    // The condition flag is captured on the same edge that may enter WRITEBACK,
    // so the write-enable decode has to look at the live value in EXECUTE.
    assign cndNext = (state == EXECUTE) ? cnd_i : cndQ;
    assign wbNext  = (nextState == WRITEBACK) && !((icodeQ == 4'h2) && !cndNext);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            stat         <= STAT_AOK;
            icodeQ       <= 4'h0;
            cndQ         <= 1'b0;
            waitCnt      <= '0;
            retired      <= '0;
            fetch_en_o   <= 1'b0;
            decode_en_o  <= 1'b0;
            execute_en_o <= 1'b0;
            memory_en_o  <= 1'b0;
            mem_req_o    <= 1'b0;
            wb_en_o      <= 1'b0;
            pc_en_o      <= 1'b0;
        end else begin
            state        <= nextState;
            stat         <= nextStat;
            fetch_en_o   <= (nextState == FETCH);
            decode_en_o  <= (nextState == DECODE);
            execute_en_o <= (nextState == EXECUTE);
            memory_en_o  <= (nextState == MEMORY);
            mem_req_o    <= (nextState == MEMORY);
            wb_en_o      <= wbNext;
            pc_en_o      <= (nextState == PCUPD);
            if (state == FETCH)   icodeQ <= icode_i;
            if (state == EXECUTE) cndQ   <= cnd_i;
            if (state != MEMORY)  waitCnt <= '0;
            else if (!mem_ack_i)  waitCnt <= waitCnt + WAIT_W'(1);
            if (restart)             retired <= '0;
            else if (state == PCUPD) retired <= retired + CNT_W'(1);
        end
    end

    assign stat_o    = stat;
    assign busy_o    = (state != IDLE) && (state != HALTED);
    assign retired_o = retired;

endmodule

// File: tb/tb_y86_stage_ctrl.sv
// Directed bench for y86_stage_ctrl: a per-instruction vector table plus hand-written
// sequences for timeout, faults, halt/restart, async reset and counter wrap.
module tb_y86_stage_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [3:0]  icode_i;
    logic        instr_valid_i;
    logic        imem_error_i;
    logic        cnd_i;
    logic        mem_ack_i;
    logic        dmem_error_i;
    logic        fetchEn, decodeEn, executeEn, memoryEn, pcEn, wbEn, memReq, busy;
    logic [2:0]  stat;
    logic [31:0] retired;
    logic        sFetchEn, sDecodeEn, sExecuteEn, sMemoryEn, sPcEn, sWbEn, sMemReq, sBusy;
    logic [2:0]  sStat;
    logic [3:0]  sRetired;

    int total = 0;
    int bad   = 0;

    y86_stage_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .icode_i(icode_i),
        .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i), .cnd_i(cnd_i),
        .mem_ack_i(mem_ack_i), .dmem_error_i(dmem_error_i),
        .fetch_en_o(fetchEn), .decode_en_o(decodeEn), .execute_en_o(executeEn),
        .memory_en_o(memoryEn), .pc_en_o(pcEn), .wb_en_o(wbEn), .mem_req_o(memReq),
        .stat_o(stat), .busy_o(busy), .retired_o(retired)
    );

    y86_stage_ctrl #(.CNT_W(4)) dutSmall (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .icode_i(icode_i),
        .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i), .cnd_i(cnd_i),
        .mem_ack_i(mem_ack_i), .dmem_error_i(dmem_error_i),
        .fetch_en_o(sFetchEn), .decode_en_o(sDecodeEn), .execute_en_o(sExecuteEn),
        .memory_en_o(sMemoryEn), .pc_en_o(sPcEn), .wb_en_o(sWbEn), .mem_req_o(sMemReq),
        .stat_o(sStat), .busy_o(sBusy), .retired_o(sRetired)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] icode;
        logic       cnd;
        int         ackDelay;
        int         expCycles;
        int         expMem;
        int         expWb;
        int         expTrace;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulseStart();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Called at the sample point of a FETCH cycle; returns at the next FETCH sample.
    task automatic runInstr(input logic [3:0] ic, input logic cn, input int ackDelay,
                            output int cycles, output int memC, output int reqC,
                            output int wbC, output int trace);
        bit done;
        int code;
        done = 0;
        cycles = 0; memC = 0; reqC = 0; wbC = 0; trace = 0;
        icode_i = ic;
        cnd_i   = cn;
        for (int k = 0; k < 40 && !done; k++) begin
            cycles++;
            check("enable_onehot", ($countones({fetchEn, decodeEn, executeEn, memoryEn, wbEn, pcEn}) <= 1), 1);
            check("busy_running", busy, 1);
            code = fetchEn ? 1 : decodeEn ? 2 : executeEn ? 3 : memoryEn ? 4 : wbEn ? 5 : pcEn ? 6 : 0;
            trace = trace * 8 + code;
            if (memoryEn) begin
                memC++;
                mem_ack_i = (memC > ackDelay);
            end else begin
                mem_ack_i = 1'b0;
            end
            if (memReq) reqC++;
            if (wbEn) wbC++;
            if (pcEn) done = 1;
            step();
        end
        mem_ack_i = 1'b0;
        if (!done) check("instr_timeout", 0, 1);
    endtask

    initial begin
        int cyc, memC, reqC, wbC, trace, expRet, k;

        vecs[0]  = '{4'h6, 1'b0, 0, 5, 0, 1, 'o12356};
        vecs[1]  = '{4'h1, 1'b0, 0, 4, 0, 0, 'o1236};
        vecs[2]  = '{4'h7, 1'b1, 0, 4, 0, 0, 'o1236};
        vecs[3]  = '{4'h2, 1'b1, 0, 5, 0, 1, 'o12356};
        vecs[4]  = '{4'h2, 1'b0, 0, 5, 0, 0, 'o12306};
        vecs[5]  = '{4'h3, 1'b0, 0, 5, 0, 1, 'o12356};
        vecs[6]  = '{4'h4, 1'b0, 0, 5, 1, 0, 'o12346};
        vecs[7]  = '{4'h5, 1'b0, 3, 9, 4, 1, 'o123444456};
        vecs[8]  = '{4'h8, 1'b0, 0, 6, 1, 1, 'o123456};
        vecs[9]  = '{4'h9, 1'b0, 0, 6, 1, 1, 'o123456};
        vecs[10] = '{4'hA, 1'b0, 1, 7, 2, 1, 'o1234456};
        vecs[11] = '{4'hB, 1'b0, 0, 6, 1, 1, 'o123456};

        rst_n_i = 1'b0; start_i = 1'b0; icode_i = 4'h1; instr_valid_i = 1'b1;
        imem_error_i = 1'b0; cnd_i = 1'b0; mem_ack_i = 1'b0; dmem_error_i = 1'b0;
        #12;
        check("reset_enables", {fetchEn, decodeEn, executeEn, memoryEn, wbEn, pcEn, memReq}, 0);
        check("reset_stat", stat, 1);
        check("reset_busy", busy, 0);
        check("reset_retired", retired, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        check("idle_hold_busy", busy, 0);

        pulseStart();
        check("start_fetch", fetchEn, 1);
        expRet = 0;
        foreach (vecs[i]) begin
            runInstr(vecs[i].icode, vecs[i].cnd, vecs[i].ackDelay, cyc, memC, reqC, wbC, trace);
            expRet++;
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].expCycles);
            check($sformatf("v%0d_mem", i), memC, vecs[i].expMem);
            check($sformatf("v%0d_req", i), reqC, vecs[i].expMem);
            check($sformatf("v%0d_wb", i), wbC, vecs[i].expWb);
            check($sformatf("v%0d_trace", i), trace, vecs[i].expTrace);
            check($sformatf("v%0d_retired", i), retired, expRet);
        end

        // pushq with no ack: timeout after 8 MEMORY cycles
        icode_i = 4'hA;
        memC = 0;
        for (k = 0; k < 40; k++) begin
            if (memoryEn) memC++;
            if (!busy) break;
            step();
        end
        check("timeout_mem_cycles", memC, 8);
        check("timeout_stat", stat, 3);
        check("timeout_retired", retired, expRet);
        check("timeout_req", memReq, 0);

        pulseStart();
        check("restart_stat", stat, 1);
        check("restart_retired", retired, 0);
        runInstr(4'h1, 1'b0, 0, cyc, memC, reqC, wbC, trace);
        runInstr(4'h1, 1'b0, 0, cyc, memC, reqC, wbC, trace);
        icode_i = 4'h0;
        step();
        check("halt_stat", stat, 2);
        check("halt_busy", busy, 0);
        check("halt_retired", retired, 2);
        step();
        check("halted_hold_retired", retired, 2);
        pulseStart();
        check("halt_restart_stat", stat, 1);
        check("halt_restart_retired", retired, 0);
        check("halt_restart_fetch", fetchEn, 1);

        icode_i = 4'hC;
        step();
        check("ins_stat", stat, 4);
        pulseStart();
        icode_i = 4'h0;
        imem_error_i = 1'b1;
        step();
        check("adr_priority_stat", stat, 3);
        imem_error_i = 1'b0;

        // mrmovq whose ack reports a data fault
        pulseStart();
        icode_i = 4'h5;
        for (k = 0; k < 10 && !memoryEn; k++) step();
        mem_ack_i = 1'b1;
        dmem_error_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        dmem_error_i = 1'b0;
        check("dmem_err_stat", stat, 3);
        check("dmem_err_busy", busy, 0);
        check("dmem_err_retired", retired, 0);

        // reset during a MEMORY wait
        pulseStart();
        icode_i = 4'h5;
        for (k = 0; k < 10 && !memoryEn; k++) step();
        step();
        check("wait_req_high", memReq, 1);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_rst_req", memReq, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_stat", stat, 1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();

        pulseStart();
        for (int n = 0; n < 16; n++) runInstr(4'h1, 1'b0, 0, cyc, memC, reqC, wbC, trace);
        check("wrap_small_retired", sRetired, 0);
        check("wrap_main_retired", retired, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
